// File: rtl/mmio_port_responder.sv
// mmio_port_responder: memory-mapped I/O block on the MIPS data bus.
// It holds a 32-bit output port register and synchronises an 8-bit input port.
// Every change seen on the input port is queued in an event FIFO, and software
// drains that FIFO with loads. Loads answer exactly one cycle after the request.
module mmio_port_responder #(
   parameter logic [31:0] BASE_ADDR  = 32'h1001_0100,
   parameter int          FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic [7:0]  PortIn,
   output logic        IoHit,
   output logic        ReadValid,
   output logic [31:0] ReadData,
   output logic [31:0] PortOut,
   output logic        FifoIrq
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [1:0] OFF_PORTOUT  = 2'd0;
   localparam logic [1:0] OFF_PORTIN   = 2'd1;
   localparam logic [1:0] OFF_FIFODATA = 2'd2;
   localparam logic [1:0] OFF_STATUS   = 2'd3;

   // input synchroniser and change detector
   logic [7:0] sync1, sync2, prev;

   // event FIFO state
   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count, count_n;
   logic          overflow;

   // decoded request
   logic       hit;
   logic [1:0] off;
   logic       rd_req, wr_req;

   // FIFO control
   logic        empty, full;
   logic        push, push_ok, pop_ok;
   logic        ovf_set, ovf_clr;
   logic [7:0]  pop_data;
   logic [4:0]  count5;
   logic [31:0] status;
   logic [31:0] rd_mux;

   assign hit    = (Address[31:4] == BASE_ADDR[31:4]);
   assign off    = Address[3:2];
   // a simultaneous write wins, so the read half of the request is dropped
   assign wr_req = MemWrite && hit;
   assign rd_req = MemRead && hit && !MemWrite;

   assign empty   = (count == '0);
   assign full    = (count == CW'(FIFO_DEPTH));
   assign push    = (sync2 != prev);
   // a full FIFO still accepts a push when a pop frees the slot in the same cycle
   assign pop_ok  = rd_req && (off == OFF_FIFODATA) && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign ovf_set = push && full && !pop_ok;
   assign ovf_clr = wr_req && (off == OFF_STATUS) && WriteData[2];

   // the popped value is the head before this edge; an empty pop reads as 0
   assign pop_data = empty ? 8'h00 : mem[rd_ptr];
   assign count5   = 5'(count);
   assign status   = {24'b0, count5, overflow, full, empty};

   // next-cycle FIFO occupancy
   always_comb begin
      count_n = count;
      if (push_ok && !pop_ok)
         count_n = count + CW'(1);
      else if (!push_ok && pop_ok)
         count_n = count - CW'(1);
   end

   // load response data selected by register offset
   always_comb begin
      rd_mux = '0;
      case (off)
         OFF_PORTOUT:  rd_mux = PortOut;
         OFF_PORTIN:   rd_mux = {24'b0, sync2};
         OFF_FIFODATA: rd_mux = {24'b0, pop_data};
         OFF_STATUS:   rd_mux = status;
         default:      rd_mux = '0;
      endcase
   end

   // two-flop synchroniser plus the previous sample used for change detection
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         prev  <= '0;
      end else begin
         sync1 <= PortIn;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   // FIFO storage, no reset needed since the pointers define validity
   always_ff @(posedge clk) begin
      if (!reset && push_ok)
         mem[wr_ptr] <= sync2;
   end

   // FIFO pointers, count, sticky overflow and interrupt
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         FifoIrq  <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop_ok)
            rd_ptr <= rd_ptr + PW'(1);
         count   <= count_n;
         FifoIrq <= (count_n != '0);
         // a set in the same cycle as a clear takes priority
         if (ovf_set)
            overflow <= 1'b1;
         else if (ovf_clr)
            overflow <= 1'b0;
      end
   end

   // bus response and output port register
   always_ff @(posedge clk) begin
      if (reset) begin
         PortOut   <= '0;
         ReadData  <= '0;
         ReadValid <= 1'b0;
         IoHit     <= 1'b0;
      end else begin
         IoHit     <= (MemRead || MemWrite) && hit;
         ReadValid <= rd_req;
         ReadData  <= rd_req ? rd_mux : '0;
         if (wr_req && (off == OFF_PORTOUT))
            PortOut <= WriteData;
      end
   end

endmodule

// File: tb/tb_mmio_port_responder.sv
// Self-checking bench for mmio_port_responder: a table of single-request vectors
// followed by hand-written sequences for the FIFO and reset corner cases.
module tb_mmio_port_responder;

   localparam logic [31:0] BASE = 32'h1001_0100;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemRead, MemWrite;
   logic [31:0] Address, WriteData;
   logic [7:0]  PortIn;
   logic        IoHit, ReadValid, FifoIrq;
   logic [31:0] ReadData, PortOut;

   int checks   = 0;
   int failures = 0;

   mmio_port_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(8)) dut (
      .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
      .Address(Address), .WriteData(WriteData), .PortIn(PortIn),
      .IoHit(IoHit), .ReadValid(ReadValid), .ReadData(ReadData),
      .PortOut(PortOut), .FifoIrq(FifoIrq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        mr;
      logic        mw;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_hit;
      logic        exp_valid;
      logic [31:0] exp_data;
      logic [31:0] exp_portout;
   } vec_t;

   vec_t vecs[12];

   // one clock edge; outputs are sampled 1 ns after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic idle();
      MemRead = 1'b0; MemWrite = 1'b0; Address = BASE; WriteData = '0;
   endtask

   task automatic req(input logic mr, input logic mw, input logic [31:0] a, input logic [31:0] d);
      MemRead = mr; MemWrite = mw; Address = a; WriteData = d;
      tick();
      idle();
   endtask

   task automatic ld_chk(input string name, input logic [31:0] off, input logic [31:0] exp);
      req(1'b1, 1'b0, BASE + off, 32'h0);
      chk({name, "_valid"}, {31'b0, ReadValid}, 32'd1);
      chk(name, ReadData, exp);
   endtask

   task automatic drain(input string name, input logic [7:0] v);
      ld_chk(name, 32'h8, {24'b0, v});
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got 0 expected 1");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0]  = '{1'b0, 1'b1, BASE + 32'h0,  32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0,         32'hDEAD_BEEF};
      vecs[1]  = '{1'b1, 1'b0, BASE + 32'h0,  32'h0,         1'b1, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
      vecs[2]  = '{1'b1, 1'b0, BASE + 32'h4,  32'h0,         1'b1, 1'b1, 32'h0,         32'hDEAD_BEEF};
      vecs[3]  = '{1'b1, 1'b0, BASE + 32'hC,  32'h0,         1'b1, 1'b1, 32'h1,         32'hDEAD_BEEF};
      vecs[4]  = '{1'b1, 1'b0, BASE + 32'h10, 32'h0,         1'b0, 1'b0, 32'h0,         32'hDEAD_BEEF};
      vecs[5]  = '{1'b1, 1'b0, BASE - 32'h4,  32'h0,         1'b0, 1'b0, 32'h0,         32'hDEAD_BEEF};
      vecs[6]  = '{1'b1, 1'b1, BASE + 32'h0,  32'h1234_5678, 1'b1, 1'b0, 32'h0,         32'h1234_5678};
      vecs[7]  = '{1'b0, 1'b1, BASE + 32'h4,  32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0,         32'h1234_5678};
      vecs[8]  = '{1'b0, 1'b0, BASE + 32'h0,  32'h0,         1'b0, 1'b0, 32'h0,         32'h1234_5678};
      vecs[9]  = '{1'b1, 1'b0, BASE + 32'h8,  32'h0,         1'b1, 1'b1, 32'h0,         32'h1234_5678};
      vecs[10] = '{1'b1, 1'b0, BASE + 32'h3,  32'h0,         1'b1, 1'b1, 32'h1234_5678, 32'h1234_5678};
      vecs[11] = '{1'b0, 1'b1, BASE + 32'hC,  32'h4,         1'b1, 1'b0, 32'h0,         32'h1234_5678};

      // reset state
      reset = 1'b1; PortIn = 8'h00; idle();
      tick(); tick();
      reset = 1'b0;
      chk("rst_portout", PortOut, 32'h0);
      chk("rst_readdata", ReadData, 32'h0);
      chk("rst_valid", {31'b0, ReadValid}, 32'h0);
      chk("rst_iohit", {31'b0, IoHit}, 32'h0);
      chk("rst_irq", {31'b0, FifoIrq}, 32'h0);

      // single-request table with the input port idle
      for (int i = 0; i < 12; i++) begin
         req(vecs[i].mr, vecs[i].mw, vecs[i].addr, vecs[i].wdata);
         chk($sformatf("vec%0d_hit", i), {31'b0, IoHit}, {31'b0, vecs[i].exp_hit});
         chk($sformatf("vec%0d_valid", i), {31'b0, ReadValid}, {31'b0, vecs[i].exp_valid});
         chk($sformatf("vec%0d_data", i), ReadData, vecs[i].exp_data);
         chk($sformatf("vec%0d_portout", i), PortOut, vecs[i].exp_portout);
         chk($sformatf("vec%0d_irq", i), {31'b0, FifoIrq}, 32'h0);
      end

      // single input change reaches the FIFO on the third edge
      PortIn = 8'h5A;
      tick(); tick();
      chk("t2_irq_early", {31'b0, FifoIrq}, 32'h0);
      tick();
      chk("t2_irq", {31'b0, FifoIrq}, 32'h1);
      ld_chk("t2_status1", 32'hC, 32'h08);
      ld_chk("t2_portin", 32'h4, 32'h5A);
      ld_chk("t2_pop", 32'h8, 32'h5A);
      chk("t2_irq_after_pop", {31'b0, FifoIrq}, 32'h0);
      ld_chk("t2_status0", 32'hC, 32'h01);

      // nine changes overrun an eight-entry FIFO
      for (int v = 1; v <= 9; v++) begin
         PortIn = 8'(v);
         tick();
      end
      tick(); tick(); tick();
      ld_chk("t3_status_full", 32'hC, 32'h46);
      for (int v = 1; v <= 8; v++)
         drain($sformatf("t3_pop%0d", v), 8'(v));
      ld_chk("t3_status_ovf", 32'hC, 32'h05);
      req(1'b0, 1'b1, BASE + 32'hC, 32'h0000_0004);
      ld_chk("t3_status_clr", 32'hC, 32'h01);

      // full FIFO: push and pop land on the same edge
      for (int v = 8'h11; v <= 8'h18; v++) begin
         PortIn = 8'(v);
         tick();
      end
      tick(); tick(); tick();
      ld_chk("t4_status_full", 32'hC, 32'h42);
      PortIn = 8'h20;
      tick(); tick();
      ld_chk("t4_pop_oldest", 32'h8, 32'h11);
      ld_chk("t4_status_after", 32'hC, 32'h42);
      for (int v = 8'h12; v <= 8'h18; v++)
         drain($sformatf("t4_drain%0h", v), 8'(v));
      drain("t4_drain_last", 8'h20);

      // empty pop has no side effect
      ld_chk("t5_empty_pop", 32'h8, 32'h0);
      ld_chk("t5_status", 32'hC, 32'h01);
      req(1'b1, 1'b0, BASE + 32'h10, 32'h0);
      chk("t5_miss_valid", {31'b0, ReadValid}, 32'h0);
      chk("t5_miss_hit", {31'b0, IoHit}, 32'h0);

      // reset lands on the edge that would return a pending load
      for (int v = 8'h31; v <= 8'h33; v++) begin
         PortIn = 8'(v);
         tick();
      end
      tick(); tick(); tick();
      ld_chk("t6_status3", 32'hC, 32'h18);
      MemRead = 1'b1; Address = BASE; reset = 1'b1; PortIn = 8'h00;
      tick();
      idle(); reset = 1'b0;
      chk("t6_valid", {31'b0, ReadValid}, 32'h0);
      chk("t6_portout", PortOut, 32'h0);
      chk("t6_irq", {31'b0, FifoIrq}, 32'h0);
      ld_chk("t6_status", 32'hC, 32'h01);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
